// File: rtl/serial_paralelo_sync.sv
// Serial-to-parallel receiver: MSB-first shift register, comma-based word alignment
// and HUNT/VERIFY/LOCKED lock tracking, all clocked by the single bit clock.
module serial_paralelo_sync #(
   parameter int unsigned      WIDTH      = 8,
   parameter logic [WIDTH-1:0] COMMA      = 8'hBC,
   parameter int unsigned      LOCK_COUNT = 4,
   parameter int unsigned      LOSS_COUNT = 3
) (
   input  logic             clk_32f,
   input  logic             reset,
   input  logic             data_in,
   output logic [WIDTH-1:0] data_out,
   output logic             valid_out,
   output logic             active,
   output logic             misalign
);

   localparam int unsigned BW = $clog2(WIDTH);
   localparam int unsigned CW = $clog2(LOCK_COUNT + 1);
   localparam int unsigned EW = $clog2(LOSS_COUNT + 1);

   localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
   localparam logic [CW-1:0] LOCK_CNT = CW'(LOCK_COUNT);
   localparam logic [EW-1:0] LOSS_CNT = EW'(LOSS_COUNT);

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] sr;
   logic [BW-1:0]    bit_cnt;
   logic [BW-1:0]    bit_cnt_nxt;
   logic [CW-1:0]    comma_cnt;
   logic [CW-1:0]    comma_cnt_nxt;
   logic [CW-1:0]    comma_inc;
   logic [EW-1:0]    err_cnt;
   logic [EW-1:0]    err_cnt_nxt;
   logic [EW-1:0]    err_inc;
   logic [WIDTH-1:0] data_nxt;
   logic             valid_nxt;
   logic             misalign_nxt;
   logic             is_comma;
   logic             wb;

   assign is_comma = (sr == COMMA);
   assign wb       = (state != HUNT) && (bit_cnt == '0);

   // Saturating increments; the compare against the limit happens on the incremented value.
   assign comma_inc = (comma_cnt == LOCK_CNT) ? comma_cnt : comma_cnt + CW'(1);
   assign err_inc   = (err_cnt == LOSS_CNT) ? err_cnt : err_cnt + EW'(1);

   always_comb begin
      // NOTE: every variable gets a default first, so no branch can leave one unassigned and infer a latch.
      state_nxt     = state;
      bit_cnt_nxt   = bit_cnt;
      comma_cnt_nxt = comma_cnt;
      err_cnt_nxt   = err_cnt;
      data_nxt      = '0;
      valid_nxt     = 1'b0;
      misalign_nxt  = 1'b0;

      if (state != HUNT) begin
         bit_cnt_nxt = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BW'(1);
      end

      case (state)
         HUNT: begin
            // The comma just completed in sr, so the next word ends WIDTH edges from now.
            if (is_comma) begin
               bit_cnt_nxt   = BW'(1);
               comma_cnt_nxt = CW'(1);
               state_nxt     = (LOCK_COUNT == 1) ? LOCKED : VERIFY;
            end
         end

         VERIFY: begin
            if (wb) begin
               if (is_comma) begin
                  comma_cnt_nxt = comma_inc;
                  if (comma_inc == LOCK_CNT) begin
                     state_nxt = LOCKED;
                  end
               end else begin
                  comma_cnt_nxt = '0;
                  state_nxt     = HUNT;
               end
            end
         end

         LOCKED: begin
            data_nxt = data_out;
            if (wb) begin
               if (is_comma) begin
                  err_cnt_nxt = '0;
               end else begin
                  data_nxt  = sr;
                  valid_nxt = 1'b1;
               end
            end else if (is_comma) begin
               // Off-boundary comma: phase has slipped; bit_cnt keeps running on purpose.
               misalign_nxt = 1'b1;
               if (err_inc == LOSS_CNT) begin
                  err_cnt_nxt = '0;
                  state_nxt   = HUNT;
               end else begin
                  err_cnt_nxt = err_inc;
               end
            end
         end

         default: begin
            state_nxt = HUNT;
         end
      endcase
   end

   always_ff @(posedge clk_32f) begin
      // NOTE: synchronous reset clears sr as well, so no stale half-comma can match right after reset.
      if (!reset) begin
         state     <= HUNT;
         sr        <= '0;
         bit_cnt   <= '0;
         comma_cnt <= '0;
         err_cnt   <= '0;
         data_out  <= '0;
         valid_out <= 1'b0;
         active    <= 1'b0;
         misalign  <= 1'b0;
      end else begin
         // NOTE: non-blocking updates keep sr's pre-edge value as the compare source for this edge.
         state     <= state_nxt;
         sr        <= {sr[WIDTH-2:0], data_in};
         bit_cnt   <= bit_cnt_nxt;
         comma_cnt <= comma_cnt_nxt;
         err_cnt   <= err_cnt_nxt;
         data_out  <= data_nxt;
         valid_out <= valid_nxt;
         active    <= (state_nxt == LOCKED);
         misalign  <= misalign_nxt;
      end
   end

endmodule

// File: tb/tb_serial_paralelo_sync.sv
// Scoreboard bench for serial_paralelo_sync: an 8-bit instance for lock, abort, slip and reset
// scenarios, and a 10-bit instance with LOCK_COUNT=2.
module tb_serial_paralelo_sync;

   localparam int         WA      = 8;
   localparam int         WB      = 10;
   localparam logic [7:0] COMMA_A = 8'hBC;
   localparam logic [9:0] COMMA_B = 10'h17C;

   logic          clk_32f = 1'b0;
   logic          reset   = 1'b0;
   logic          din_a   = 1'b0;
   logic          din_b   = 1'b0;
   logic [WA-1:0] dout_a;
   logic          valid_a;
   logic          active_a;
   logic          mis_a;
   logic [WB-1:0] dout_b;
   logic          valid_b;
   logic          active_b;
   logic          mis_b;

   int n_cmp     = 0;
   int n_mis     = 0;
   int cyc       = 0;
   int mis_cnt_a = 0;
   int mis_cnt_b = 0;
   int last_a    = -1;
   int last_b    = -1;
   int m0;

   logic [WA-1:0] q_a[$];
   logic [WB-1:0] q_b[$];

   serial_paralelo_sync #(
      .WIDTH(WA), .COMMA(COMMA_A), .LOCK_COUNT(4), .LOSS_COUNT(3)
   ) dut_a (
      .clk_32f(clk_32f), .reset(reset), .data_in(din_a), .data_out(dout_a),
      .valid_out(valid_a), .active(active_a), .misalign(mis_a)
   );

   serial_paralelo_sync #(
      .WIDTH(WB), .COMMA(COMMA_B), .LOCK_COUNT(2), .LOSS_COUNT(3)
   ) dut_b (
      .clk_32f(clk_32f), .reset(reset), .data_in(din_b), .data_out(dout_b),
      .valid_out(valid_b), .active(active_b), .misalign(mis_b)
   );

   always #5 clk_32f = ~clk_32f;

   always @(posedge clk_32f) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic send_bit_a(input logic b);
      @(negedge clk_32f);
      din_a = b;
   endtask

   task automatic send_a(input logic [WA-1:0] w);
      for (int i = WA - 1; i >= 0; i--) begin
         @(negedge clk_32f);
         din_a = w[i];
      end
   endtask

   task automatic send_b(input logic [WB-1:0] w);
      for (int i = WB - 1; i >= 0; i--) begin
         @(negedge clk_32f);
         din_b = w[i];
      end
   endtask

   task automatic do_reset();
      @(negedge clk_32f);
      reset = 1'b0;
      din_a = 1'b0;
      din_b = 1'b0;
      @(negedge clk_32f);
      check("rst_data_a",     32'(dout_a),   0);
      check("rst_valid_a",    32'(valid_a),  0);
      check("rst_active_a",   32'(active_a), 0);
      check("rst_misalign_a", 32'(mis_a),    0);
      check("rst_data_b",     32'(dout_b),   0);
      check("rst_active_b",   32'(active_b), 0);
      reset = 1'b1;
   endtask

   // Output monitors: every strobe pops one expected word; strobes must be >= WIDTH apart.
   initial forever begin
      @(negedge clk_32f);
      if (!reset) begin
         last_a = -1;
      end else if (valid_a) begin
         check("a_valid_expected", 32'(q_a.size() > 0), 1);
         if (q_a.size() > 0) check("a_data_out", 32'(dout_a), 32'(q_a.pop_front()));
         if (last_a >= 0) check("a_strobe_gap", 32'((cyc - last_a) >= WA), 1);
         last_a = cyc;
      end
      if (mis_a) mis_cnt_a = mis_cnt_a + 1;
   end

   initial forever begin
      @(negedge clk_32f);
      if (!reset) begin
         last_b = -1;
      end else if (valid_b) begin
         check("b_valid_expected", 32'(q_b.size() > 0), 1);
         if (q_b.size() > 0) check("b_data_out", 32'(dout_b), 32'(q_b.pop_front()));
         if (last_b >= 0) check("b_strobe_gap", 32'((cyc - last_b) >= WB), 1);
         last_b = cyc;
      end
      if (mis_b) mis_cnt_b = mis_cnt_b + 1;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not reach its summary in time");
      $fatal(1);
   end

   initial begin
      // T1: aligned commas from bit 0; lock lands on the edge after the 4th comma.
      do_reset();
      repeat (4) send_a(COMMA_A);
      check("t1_active_before_lock", 32'(active_a), 0);
      send_a(COMMA_A);
      check("t1_active_locked", 32'(active_a), 1);
      repeat (2) send_a(COMMA_A);
      check("t1_data_out_idle", 32'(dout_a), 0);
      check("t1_no_misalign", 32'(mis_cnt_a), 0);

      // T2: 3 junk bits shift the phase; two data words follow the locking commas.
      do_reset();
      send_bit_a(1'b0);
      send_bit_a(1'b0);
      send_bit_a(1'b1);
      repeat (4) send_a(COMMA_A);
      q_a.push_back(8'h11);
      send_a(8'h11);
      q_a.push_back(8'h22);
      send_a(8'h22);
      repeat (2) send_a(COMMA_A);
      check("t2_words_drained", 32'(q_a.size()), 0);
      check("t2_data_out_hold", 32'(dout_a), 32'h22);
      check("t2_active", 32'(active_a), 1);

      // T3: a data word during VERIFY aborts to HUNT; 4 fresh commas relock.
      do_reset();
      repeat (3) send_a(COMMA_A);
      send_a(8'h55);
      repeat (4) send_a(COMMA_A);
      check("t3_active_after_abort", 32'(active_a), 0);
      send_a(COMMA_A);
      check("t3_relocked", 32'(active_a), 1);

      // T4: one extra bit slips the phase; the old boundary sees 0x5E three times.
      do_reset();
      repeat (5) send_a(COMMA_A);
      check("t4_locked", 32'(active_a), 1);
      m0 = mis_cnt_a;
      send_bit_a(1'b0);
      repeat (3) begin
         q_a.push_back(8'h5E);
         send_a(COMMA_A);
      end
      send_a(COMMA_A);
      check("t4_misalign_pulses", 32'(mis_cnt_a - m0), 3);
      check("t4_active_lost", 32'(active_a), 0);
      check("t4_data_cleared", 32'(dout_a), 0);
      repeat (3) send_a(COMMA_A);
      check("t4_not_yet_relocked", 32'(active_a), 0);
      send_a(COMMA_A);
      check("t4_relocked", 32'(active_a), 1);
      q_a.push_back(8'h81);
      send_a(8'h81);
      repeat (2) send_a(COMMA_A);
      check("t4_new_phase_word", 32'(dout_a), 32'h81);
      check("t4_words_drained", 32'(q_a.size()), 0);
      check("t4_misalign_total", 32'(mis_cnt_a - m0), 3);

      // T5: reset for one clock in the middle of a data word while locked.
      do_reset();
      repeat (5) send_a(COMMA_A);
      q_a.push_back(8'h11);
      send_a(8'h11);
      send_bit_a(1'b0);
      send_bit_a(1'b0);
      send_bit_a(1'b1);
      send_bit_a(1'b0);
      check("t5_data_before_reset", 32'(dout_a), 32'h11);
      check("t5_active_before_reset", 32'(active_a), 1);
      check("t5_words_drained", 32'(q_a.size()), 0);
      do_reset();
      send_a(8'h00);
      check("t5_hunt_active", 32'(active_a), 0);
      check("t5_hunt_data", 32'(dout_a), 0);
      repeat (4) send_a(COMMA_A);
      check("t5_relock_pending", 32'(active_a), 0);
      send_a(COMMA_A);
      check("t5_relocked", 32'(active_a), 1);

      // T6: 10-bit instance, two commas lock, one all-ones word.
      do_reset();
      repeat (2) send_b(COMMA_B);
      check("t6_active_before_lock", 32'(active_b), 0);
      q_b.push_back(10'h3FF);
      send_b(10'h3FF);
      check("t6_active", 32'(active_b), 1);
      repeat (2) send_b(COMMA_B);
      check("t6_data_out", 32'(dout_b), 32'h3FF);
      check("t6_words_drained", 32'(q_b.size()), 0);
      check("t6_no_misalign", 32'(mis_cnt_b), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
